// File: rtl/plru_tree_walker.sv
// Per-set tree pseudo-LRU state store with a sequential walker: touches climb
// leaf->root one level per cycle, victim queries descend root->leaf.
module plru_tree_walker #(
  parameter int s_assoc = 8,
  parameter int s_width = $clog2(s_assoc),
  parameter int s_sets  = 16,
  parameter int s_index = $clog2(s_sets)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [s_index-1:0] req_set,
  input  logic [s_width-1:0] req_way,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [s_width-1:0] resp_way,
  output logic               busy
);

  localparam int n_nodes = s_assoc - 1;
  // Cursor spans every tree node including leaves (up to 2*s_assoc-2).
  localparam int cw = s_width + 1;

  typedef enum logic [2:0] {IDLE, UP, DOWN, CLR_ALL, RESP} state_t;

  state_t             state_reg, state_next;
  logic [cw-1:0]      cursor_reg, cursor_next;
  logic [s_index-1:0] set_reg, set_next;
  logic [s_index-1:0] clr_cnt_reg, clr_cnt_next;
  logic [s_width-1:0] resp_way_reg, resp_way_next;
  logic [n_nodes-1:0] plru_reg [s_sets];

  logic               wr_en;
  logic [s_index-1:0] wr_idx;
  logic [n_nodes-1:0] wr_row;
  logic [n_nodes-1:0] cur_row;
  logic [n_nodes-1:0] node_sel;
  logic [n_nodes-1:0] parent_sel;
  logic [cw-1:0]      parent;
  logic [cw-1:0]      child;
  logic               cur_bit;

  assign cur_row = plru_reg[set_reg];
  assign parent  = (cursor_reg - cw'(1)) >> 1;

  // One-hot decode of the cursor and its parent onto the node bits of a set.
  genvar gi;
  generate
    for (gi = 0; gi < n_nodes; gi++) begin : g_node
      assign node_sel[gi]   = (cursor_reg == cw'(gi));
      assign parent_sel[gi] = (parent == cw'(gi));
    end
  endgenerate

  assign cur_bit = |(cur_row & node_sel);
  assign child   = {cursor_reg[cw-2:0], 1'b0} + cw'(1) + cw'(cur_bit);

  always_comb begin
    state_next    = state_reg;
    cursor_next   = cursor_reg;
    set_next      = set_reg;
    clr_cnt_next  = clr_cnt_reg;
    resp_way_next = resp_way_reg;
    wr_en         = 1'b0;
    wr_idx        = set_reg;
    wr_row        = cur_row;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          set_next = req_set;
          case (req_op)
            2'b00: begin
              cursor_next   = cw'(req_way) + cw'(n_nodes);
              resp_way_next = req_way;
              state_next    = UP;
            end
            2'b01: begin
              cursor_next = '0;
              state_next  = DOWN;
            end
            2'b10: begin
              wr_en         = 1'b1;
              wr_idx        = req_set;
              wr_row        = '0;
              resp_way_next = '0;
              state_next    = RESP;
            end
            default: begin
              clr_cnt_next  = '0;
              resp_way_next = '0;
              state_next    = CLR_ALL;
            end
          endcase
        end
      end
      UP: begin
        // Odd cursor = left child, so the LRU side becomes the right (1).
        wr_en       = 1'b1;
        wr_row      = (cur_row & ~parent_sel) | (parent_sel & {n_nodes{cursor_reg[0]}});
        cursor_next = parent;
        if (parent == '0) state_next = RESP;
      end
      DOWN: begin
        cursor_next = child;
        if (child >= cw'(n_nodes)) begin
          resp_way_next = s_width'(child - cw'(n_nodes));
          state_next    = RESP;
        end
      end
      CLR_ALL: begin
        wr_en        = 1'b1;
        wr_idx       = clr_cnt_reg;
        wr_row       = '0;
        clr_cnt_next = clr_cnt_reg + s_index'(1);
        if (clr_cnt_reg == s_index'(s_sets - 1)) state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cursor_reg   <= '0;
      set_reg      <= '0;
      clr_cnt_reg  <= '0;
      resp_way_reg <= '0;
      for (int s = 0; s < s_sets; s++) plru_reg[s] <= '0;
    end else begin
      state_reg    <= state_next;
      cursor_reg   <= cursor_next;
      set_reg      <= set_next;
      clr_cnt_reg  <= clr_cnt_next;
      resp_way_reg <= resp_way_next;
      if (wr_en) plru_reg[wr_idx] <= wr_row;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_way   = resp_way_reg;

endmodule

// File: tb/tb_plru_tree_walker.sv
// Bench for plru_tree_walker: directed vector table, hand-written corner
// sequences, then randomized operations against a path-based PLRU model.
module tb_plru_tree_walker;

  localparam int A  = 8;
  localparam int W  = 3;
  localparam int S  = 16;
  localparam int SI = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [SI-1:0] req_set = '0;
  logic [W-1:0]  req_way = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [W-1:0]  resp_way;
  logic          busy;

  int checks = 0;
  int failures = 0;

  plru_tree_walker #(.s_assoc(A), .s_sets(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_set(req_set), .req_way(req_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_way(resp_way),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: per-set tree bits addressed by walking the way's binary digits
  // from the root (MSB first); a 1 means the right subtree is least recent.
  int mbits [S][A];

  function automatic void m_touch(int s, int w);
    int n = 0;
    for (int l = W - 1; l >= 0; l--) begin
      int b = (w >> l) & 1;
      mbits[s][n] = 1 - b;
      n = 2 * n + 1 + b;
    end
  endfunction

  function automatic int m_victim(int s);
    int n = 0;
    int w = 0;
    for (int l = 0; l < W; l++) begin
      int b = mbits[s][n];
      w = (w << 1) | b;
      n = 2 * n + 1 + b;
    end
    return w;
  endfunction

  function automatic void m_clear(int s);
    for (int n = 0; n < A; n++) mbits[s][n] = 0;
  endfunction

  function automatic int m_row(int s);
    int r = 0;
    for (int n = 0; n < A - 1; n++) r |= mbits[s][n] << n;
    return r;
  endfunction

  function automatic void m_apply(int op, int s, int w);
    case (op)
      0: m_touch(s, w);
      2: m_clear(s);
      3: for (int i = 0; i < S; i++) m_clear(i);
      default: ;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rows(input string name);
    int bad = 0;
    for (int s = 0; s < S; s++)
      if (int'(dut.plru_reg[s]) != m_row(s)) bad++;
    chk(name, bad, 0);
  endtask

  // Issue one request, wait for the response, hold resp_ready low for
  // 'hold' response cycles, then complete the handshake.
  task automatic run_op(input int op, input int s, input int w, input int hold,
                        output int got_way, output int lat);
    int held_way;
    @(negedge clk);
    chk("idle_ready", int'(req_ready), 1);
    chk("idle_resp_valid", int'(resp_valid), 0);
    req_valid  = 1'b1;
    req_op     = op[1:0];
    req_set    = s[SI-1:0];
    req_way    = w[W-1:0];
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    got_way = -1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_after_accept", int'(busy), 1);
        chk("ready_after_accept", int'(req_ready), 0);
      end
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      chk("resp_timeout", 0, 1);
    end else begin
      got_way = int'(resp_way);
      held_way = got_way;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", int'(resp_valid), 1);
        chk("hold_way", int'(resp_way), held_way);
        chk("hold_ready", int'(req_ready), 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int op;
    int set;
    int way;
    int exp_way;
    int exp_lat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gw, lat, op, s, w, hold, ew, el, r;
    string nm;

    tbl[0]  = '{1, 3, 0, 0, 4};
    tbl[1]  = '{0, 3, 0, 0, 4};
    tbl[2]  = '{1, 3, 0, 4, 4};
    tbl[3]  = '{0, 3, 4, 4, 4};
    tbl[4]  = '{1, 3, 0, 2, 4};
    tbl[5]  = '{1, 5, 0, 0, 4};
    tbl[6]  = '{0, 7, 5, 5, 4};
    tbl[7]  = '{2, 3, 0, 0, 1};
    tbl[8]  = '{1, 3, 0, 0, 4};
    tbl[9]  = '{0, 9, 3, 3, 4};
    tbl[10] = '{3, 0, 0, 0, 17};
    tbl[11] = '{1, 7, 0, 0, 4};

    for (int i = 0; i < S; i++) m_clear(i);

    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_way", int'(resp_way), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].set, tbl[i].way, 0, gw, lat);
      m_apply(tbl[i].op, tbl[i].set, tbl[i].way);
      $display("vec %0d op=%0d set=%0d way=%0d -> resp_way=%0d lat=%0d", i,
               tbl[i].op, tbl[i].set, tbl[i].way, gw, lat);
      nm = $sformatf("vec%0d_way", i);
      chk(nm, gw, tbl[i].exp_way);
      nm = $sformatf("vec%0d_lat", i);
      chk(nm, lat, tbl[i].exp_lat);
      nm = $sformatf("vec%0d_rows", i);
      chk_rows(nm);
    end

    // Directed node-bit pattern: touching way 0 sets nodes 0,1,3 of the set.
    run_op(0, 4, 0, 0, gw, lat);
    m_apply(0, 4, 0);
    chk("set4_nodes_013", int'(dut.plru_reg[4]), 7'h0B);

    // Response held for 5 cycles with resp_ready low.
    run_op(1, 4, 0, 5, gw, lat);
    $display("hold victim set=4 -> resp_way=%0d lat=%0d", gw, lat);
    chk("hold_victim_way", gw, 4);

    // Touch several sets, clear all, then every set must report way 0.
    for (int i = 0; i < S; i += 3) begin
      run_op(0, i, (i * 5) % A, 0, gw, lat);
      m_apply(0, i, (i * 5) % A);
    end
    run_op(3, 0, 0, 0, gw, lat);
    m_apply(3, 0, 0);
    $display("clear all -> lat=%0d", lat);
    chk("clr_all_lat", lat, 17);
    for (int i = 0; i < S; i++) begin
      run_op(1, i, 0, 0, gw, lat);
      $display("victim after clear set=%0d -> resp_way=%0d", i, gw);
      nm = $sformatf("clr_all_victim_set%0d", i);
      chk(nm, gw, 0);
    end

    // Reset asserted during the second UP cycle of a touch.
    run_op(0, 2, 6, 0, gw, lat);
    m_apply(0, 2, 6);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_set   = 4'd2;
    req_way   = 3'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < S; i++) m_clear(i);
    $display("reset mid-walk: req_ready=%0d resp_valid=%0d busy=%0d", req_ready, resp_valid, busy);
    chk("midrst_req_ready", int'(req_ready), 1);
    chk("midrst_resp_valid", int'(resp_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_resp_way", int'(resp_way), 0);
    chk_rows("midrst_rows");
    @(negedge clk);
    rst_n = 1'b1;
    r = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || !req_ready) r++;
    end
    chk("midrst_no_resp", r, 0);
    run_op(1, 2, 0, 0, gw, lat);
    chk("midrst_next_way", gw, 0);
    chk("midrst_next_lat", lat, 4);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 45) ? 0 : (r < 90) ? 1 : (r < 97) ? 2 : 3;
      s = $urandom_range(0, S - 1);
      w = $urandom_range(0, A - 1);
      hold = $urandom_range(0, 2);
      case (op)
        0: begin ew = w; el = W + 1; end
        1: begin ew = m_victim(s); el = W + 1; end
        2: begin ew = 0; el = 1; end
        default: begin ew = 0; el = S + 1; end
      endcase
      run_op(op, s, w, hold, gw, lat);
      m_apply(op, s, w);
      $display("rand %0d op=%0d set=%0d way=%0d -> resp_way=%0d (exp %0d) lat=%0d", i,
               op, s, w, gw, ew, lat);
      chk("rand_way", gw, ew);
      chk("rand_lat", lat, el);
      if ((i % 25) == 0) chk_rows("rand_rows");
    end
    chk_rows("final_rows");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
